top_tdc: RTL and testbench

TOP_TDC -- requirements
Module: top_tdc

---
 rtl/top_tdc_pkg.sv | 18 +
 rtl/top_tdc_uart_tx.sv | 61 ++++++
 rtl/top_tdc.sv | 101 ++++++++++
 tb/tb_top_tdc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/top_tdc_pkg.sv
// Shared definitions for the time-to-digital converter: FSM state encoding,
// default measurement width and UART bit period, and the 8N1 frame length.
// No ports; imported by top_tdc and uart_tx.
package top_tdc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      SEND_LO,
      SEND_HI,
      DONE
   } tdc_state_e;

   localparam int DEF_COUNT_W      = 16;
   localparam int DEF_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud
   localparam int FRAME_LEN        = 10;    // start + 8 data + stop

endpackage

// File: rtl/top_tdc_uart_tx.sv
// UART 8N1 byte serializer; start bit 0, data LSB first, stop bit 1.
// Ports: clk, reset (sync, active-low), start/data[7:0] launch a byte, tx serial
// line (idle high), busy while framing, done high in the final cycle of the stop bit.
module uart_tx
   import top_tdc_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(FRAME_LEN + 1);

   logic [CW-1:0]        clk_cnt_q;
   logic [BW-1:0]        bit_idx_q;
   logic [FRAME_LEN-1:0] shift_q;
   logic                 busy_q;
   logic                 bit_end;
   logic                 last_bit;

   assign bit_end  = busy_q && (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
   assign last_bit = (bit_idx_q == BW'(FRAME_LEN - 1));
   assign done     = bit_end && last_bit;
   assign busy     = busy_q;
   // Line is the LSB of the frame register; an all-ones register is the idle level.
   assign tx       = shift_q[0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '1;
         busy_q    <= 1'b0;
      end else if (start && (!busy_q || done)) begin
         // Accepting during the last stop-bit cycle lets bytes run back to back.
         shift_q   <= {1'b1, data, 1'b0};
         busy_q    <= 1'b1;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
      end else if (bit_end) begin
         clk_cnt_q <= '0;
         if (last_bit) begin
            busy_q  <= 1'b0;
            shift_q <= '1;
         end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
            shift_q   <= {1'b1, shift_q[FRAME_LEN-1:1]};
         end
      end else if (busy_q) begin
         clk_cnt_q <= clk_cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/top_tdc.sv
// Time-to-digital converter: counts clk cycles with stop high, then sends the
// count low byte then high byte over UART 8N1 and pulses eot once.
// Ports: clk, reset (sync, active-low), stop (window), tx (serial out), eot (strobe).
module top_tdc
   import top_tdc_pkg::*;
#(
   parameter int COUNT_W      = DEF_COUNT_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic stop,
   output logic tx,
   output logic eot
);

   tdc_state_e         state_q;
   logic [COUNT_W-1:0] cnt_q;
   logic [COUNT_W-1:0] result_q;
   logic               eot_q;

   logic [15:0] res16;
   logic        u_start;
   logic        u_busy;
   logic        u_done;
   logic [7:0]  u_data;
   logic        lo_start;
   logic        hi_start;

   // Only the low 16 bits are reported; narrower counts are zero-extended.
   assign res16 = 16'(result_q);

   // The serializer is idle on the first SEND_LO cycle, so that cycle launches
   // the low byte; its done strobe launches the high byte with no gap.
   assign lo_start = (state_q == SEND_LO) && !u_busy;
   assign hi_start = (state_q == SEND_LO) && u_done;
   assign u_start  = lo_start || hi_start;
   assign u_data   = u_busy ? res16[15:8] : res16[7:0];

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk   (clk),
      .reset (reset),
      .start (u_start),
      .data  (u_data),
      .tx    (tx),
      .busy  (u_busy),
      .done  (u_done)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         eot_q    <= 1'b0;
      end else begin
         eot_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (stop) begin
                  cnt_q   <= COUNT_W'(1);
                  state_q <= COUNT;
               end
            end
            COUNT: begin
               if (stop) begin
                  if (cnt_q != '1) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  // First low sample is the falling edge of the window.
                  result_q <= cnt_q;
                  state_q  <= SEND_LO;
               end
            end
            SEND_LO: begin
               if (hi_start) begin
                  state_q <= SEND_HI;
               end
            end
            SEND_HI: begin
               if (u_done) begin
                  state_q <= DONE;
                  eot_q   <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign eot = eot_q;

endmodule

// File: tb/tb_top_tdc.sv
// Scoreboard bench for top_tdc with CLKS_PER_BIT=4: a 16-bit and a 4-bit counter
// instance share stop/reset; monitors decode each tx report against a queue.
// No ports.
module tb_top_tdc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       stop;
   logic [1:0] tx_v;
   logic [1:0] eot_v;

   always #5 clk = ~clk;

   top_tdc #(.COUNT_W(16), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .reset(rst_n), .stop(stop), .tx(tx_v[0]), .eot(eot_v[0])
   );

   top_tdc #(.COUNT_W(4), .CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .reset(rst_n), .stop(stop), .tx(tx_v[1]), .eot(eot_v[1])
   );

   typedef struct packed {
      logic        abort;
      logic [15:0] val;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_vec   = 0;
   int n_err   = 0;
   int eot_cnt0 = 0;
   int eot_cnt1 = 0;
   int eot_exp  = 0;

   always @(negedge clk) begin
      if (eot_v[0]) eot_cnt0 <= eot_cnt0 + 1;
      if (eot_v[1]) eot_cnt1 <= eot_cnt1 + 1;
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [79:0] exp_wave(input logic [15:0] v);
      logic [9:0]  f;
      logic [79:0] w;
      w = '0;
      for (int j = 0; j < 2; j++) begin
         f = {1'b1, v[8*j +: 8], 1'b0};
         for (int t = 0; t < 10; t++)
            for (int s = 0; s < 4; s++)
               w[40*j + 4*t + s] = f[t];
      end
      return w;
   endfunction

   task automatic push(input logic [15:0] v16, input logic [15:0] v4, input logic ab);
      q0.push_back(exp_t'({ab, v16}));
      q1.push_back(exp_t'({ab, v4}));
      if (!ab) eot_exp++;
   endtask

   // Report monitor for instance d.
   task automatic mon(input int d);
      logic [79:0] wave;
      logic        aborted;
      logic        e1, e2;
      logic [7:0]  lo, hi;
      exp_t        e;
      bit          have;
      forever begin
         @(negedge clk);
         if (rst_n && !tx_v[d]) begin
            aborted = 1'b0;
            wave    = '0;
            e1      = 1'b0;
            e2      = 1'b0;
            for (int k = 1; k < 80; k++) begin
               @(negedge clk);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               wave[k] = tx_v[d];
            end
            if (!aborted) begin
               @(negedge clk);
               e1 = eot_v[d];
               @(negedge clk);
               e2 = eot_v[d];
            end
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
               n_vec++;
               n_err++;
               $display("FAIL d%0d_unexpected_frame: got a frame, required none", d);
            end else begin
               e = (d == 0) ? q0[0] : q1[0];
               check($sformatf("d%0d_abort", d), aborted, e.abort);
               if (!aborted && !e.abort) begin
                  for (int i = 0; i < 8; i++) begin
                     lo[i] = wave[4*(1+i) + 2];
                     hi[i] = wave[40 + 4*(1+i) + 2];
                  end
                  check($sformatf("d%0d_lo_byte", d), lo, e.val[7:0]);
                  check($sformatf("d%0d_hi_byte", d), hi, e.val[15:8]);
                  check($sformatf("d%0d_wave", d), wave, exp_wave(e.val));
                  check($sformatf("d%0d_eot_pulse", d), {e1, e2}, 2'b10);
               end
               if (d == 0) q0.delete(0);
               else        q1.delete(0);
            end
         end
      end
   endtask

   initial begin
      fork
         mon(0);
         mon(1);
      join_none
   end

   task automatic stop_pulse(input int n);
      @(posedge clk);
      #1 stop = 1'b1;
      repeat (n) @(posedge clk);
      #1 stop = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (q0.size() == 0 && q1.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain", ok, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      bit seen;
      rst_n = 1'b0;
      stop  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx0", tx_v[0], 1'b1);
      check("rst_eot0", eot_v[0], 1'b0);
      check("rst_tx1", tx_v[1], 1'b1);
      check("rst_eot1", eot_v[1], 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 20-cycle window
      push(16'h0014, 16'h000F, 1'b0);
      stop_pulse(20);
      wait_drain();

      // Reset pulse then a fresh 29-cycle window
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push(16'h001D, 16'h000F, 1'b0);
      stop_pulse(29);
      wait_drain();

      // 300-cycle window exercises the high byte
      push(16'h012C, 16'h000F, 1'b0);
      stop_pulse(300);
      wait_drain();

      // Reset during the low byte aborts the report
      push(16'h0014, 16'h000F, 1'b1);
      stop_pulse(20);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!tx_v[0]) begin
            seen = 1'b1;
            break;
         end
      end
      check("abort_start_seen", seen, 1'b1);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_tx0", tx_v[0], 1'b1);
      check("abort_eot0", eot_v[0], 1'b0);
      check("abort_tx1", tx_v[1], 1'b1);
      check("abort_eot1", eot_v[1], 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_drain();
      repeat (150) @(posedge clk);

      // stop toggling during transmission is ignored
      push(16'h0005, 16'h0005, 1'b0);
      stop_pulse(5);
      repeat (10) @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 stop = ((i % 5) < 2);
      end
      stop = 1'b0;
      wait_drain();

      // stop already high on return to IDLE starts the next window there
      push(16'h000A, 16'h000A, 1'b0);
      stop_pulse(10);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (eot_v[0]) begin
            seen = 1'b1;
            break;
         end
      end
      check("eot_seen", seen, 1'b1);
      push(16'h0007, 16'h0007, 1'b0);
      stop = 1'b1;
      @(posedge clk);             // DONE -> IDLE, not counted
      repeat (7) @(posedge clk);  // seven sampled-high edges from IDLE on
      #1 stop = 1'b0;
      wait_drain();
      repeat (20) @(posedge clk);

      check("eot_count0", eot_cnt0, eot_exp);
      check("eot_count1", eot_cnt1, eot_exp);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
